// File: rtl/decode_queue_pkg.sv
// Shared types and constants for the decoded-instruction queue.
// Holds iclass/cond encodings, opcode constants, the decoded-entry
// struct carried through the queue and small decode helper functions.
package decode_queue_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OPC_W     = 8;
  localparam int unsigned CLS_W     = 4;
  localparam int unsigned REG_W     = 4;
  localparam int unsigned COND_W    = 4;
  localparam int unsigned RAW_IMM_W = 8;

  typedef enum logic [CLS_W-1:0] {
    CLS_WAIT   = 4'b0000,
    CLS_R      = 4'b0001,
    CLS_I      = 4'b0010,
    CLS_LOAD   = 4'b0100,
    CLS_STORE  = 4'b0101,
    CLS_JUMP   = 4'b1000,
    CLS_BRANCH = 4'b1100,
    CLS_ILL    = 4'b1111
  } iclass_e;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_GT = 4'b0110;
  localparam logic [COND_W-1:0] COND_LE = 4'b0111;
  localparam logic [COND_W-1:0] COND_UC = 4'b1110;

  localparam logic [OPC_W-1:0] OPC_WAIT  = 8'h00;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 8'h85;
  localparam logic [OPC_W-1:0] OPC_STORE = 8'h87;
  localparam logic [OPC_W-1:0] OPC_IMM4  = 8'h4F;
  localparam logic [3:0]       NIB_ADDI   = 4'h5;
  localparam logic [3:0]       NIB_SUBI   = 4'h9;
  localparam logic [3:0]       NIB_JUMP   = 4'h4;
  localparam logic [3:0]       NIB_BRANCH = 4'hC;

  // Queue payload: immediate is kept raw with an extend-mode flag so the
  // stored width does not depend on the IMM_W parameter.
  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    iclass_e              iclass;
    logic [REG_W-1:0]     rdst;
    logic [REG_W-1:0]     rsrc;
    logic [COND_W-1:0]    cond;
    logic [RAW_IMM_W-1:0] imm8;
    logic                 imm_sx;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  function automatic logic is_r_op(input logic [OPC_W-1:0] opc);
    case (opc)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
      8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_cond(input logic [COND_W-1:0] c);
    return (c == COND_EQ) || (c == COND_NE) || (c == COND_GT) ||
           (c == COND_LE) || (c == COND_UC);
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch/execute handshake bundle for decode_queue.
// Fetch side: flush, in_valid, in_ready, instr.
// Execute side: out_valid, out_ready and decoded head fields
// (opcode, iclass, rdst, rsrc, cond, imm[IMM_W]).
// slave = the queue, master = the agent driving fetch and execute.
interface decode_queue_if #(
  parameter int unsigned IMM_W = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instr;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        opcode;
  logic [3:0]        iclass;
  logic [3:0]        rdst;
  logic [3:0]        rsrc;
  logic [3:0]        cond;
  logic [IMM_W-1:0]  imm;

  modport master (
    output flush, in_valid, instr, out_ready,
    input  in_ready, out_valid, opcode, iclass, rdst, rsrc, cond, imm
  );

  modport slave (
    input  flush, in_valid, instr, out_ready,
    output in_ready, out_valid, opcode, iclass, rdst, rsrc, cond, imm
  );
endinterface

// File: rtl/decode_queue_core.sv
// Combinational decoder: raw 16-bit instruction -> queue entry.
// Ports: instr (in, 16), entry (out, entry_t).
// Unused fields are driven to 0; unknown encodings become CLS_ILL with
// the opcode byte preserved.
module decode_core
  import decode_queue_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output entry_t             entry
);

  always_comb begin
    entry        = '0;
    entry.opcode = instr[15:8];
    entry.iclass = CLS_ILL;
    // Priority order matters: the top-nibble ADDI/SUBI forms are tested
    // before any full-byte opcode match.
    if (instr[15:12] == NIB_ADDI || instr[15:12] == NIB_SUBI) begin
      entry.iclass = CLS_I;
      entry.rdst   = instr[11:8];
      entry.imm8   = instr[7:0];
      entry.imm_sx = 1'b1;
    end else if (is_r_op(instr[15:8])) begin
      entry.iclass = CLS_R;
      entry.rdst   = instr[7:4];
      entry.rsrc   = instr[3:0];
    end else if (instr[15:8] == OPC_IMM4) begin
      entry.iclass = CLS_I;
      entry.rdst   = instr[3:0];
      entry.imm8   = {4'h0, instr[7:4]};
    end else if (instr[15:8] == OPC_STORE) begin
      entry.iclass = CLS_STORE;
      entry.rdst   = instr[7:4];
      entry.rsrc   = instr[3:0];
    end else if (instr[15:8] == OPC_LOAD) begin
      entry.iclass = CLS_LOAD;
      entry.rdst   = instr[7:4];
      entry.rsrc   = instr[3:0];
    end else if (instr[15:8] == OPC_WAIT) begin
      entry.iclass = CLS_WAIT;
    end else if (instr[15:12] == NIB_JUMP && is_cond(instr[11:8])) begin
      entry.iclass = CLS_JUMP;
      entry.cond   = instr[11:8];
      entry.imm8   = instr[7:0];
      entry.imm_sx = 1'b1;
    end else if (instr[15:12] == NIB_BRANCH && is_cond(instr[11:8])) begin
      entry.iclass = CLS_BRANCH;
      entry.cond   = instr[11:8];
      entry.imm8   = instr[7:0];
      entry.imm_sx = 1'b1;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction queue between fetch and execute.
// Ports: clk, reset_n (async active-low), bus (decode_queue_if.slave),
// and with DECODE_PERF_CNT_EN defined: perf_decoded[15:0],
// perf_illegal[15:0] (saturating push counters, cleared by reset only).
// The head entry sits in its own register, so an entry pushed in one
// cycle is visible no earlier than the next one.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IMM_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef DECODE_PERF_CNT_EN
  output logic [15:0]        perf_decoded,
  output logic [15:0]        perf_illegal,
`endif
  decode_queue_if.slave      bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t             mem [DEPTH];
  entry_t             new_entry;
  entry_t             head_q, head_n;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]   count, count_n;
  logic               in_ready_q, out_valid_q;
  logic               push_c, pop_c;

  decode_core u_core (
    .instr (bus.instr),
    .entry (new_entry)
  );

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = out_valid_q & bus.out_ready;

  // Next-state for pointers, occupancy and the head register.
  always_comb begin
    count_n  = count;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    head_n   = head_q;
    if (bus.flush) begin
      count_n  = '0;
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      head_n   = '0;
    end else begin
      if (push_c) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr_n = rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_n = count + CNT_W'(1);
        2'b01:   count_n = count - CNT_W'(1);
        default: count_n = count;
      endcase
      // Refill the head from storage, or straight from the decoder when
      // the pushed entry is the only one left.
      if (pop_c) begin
        if (count >= CNT_W'(2))
          head_n = mem[rd_ptr + PTR_W'(1)];
        else if (push_c)
          head_n = new_entry;
        else
          head_n = '0;
      end else if (push_c && count == '0) begin
        head_n = new_entry;
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      count       <= count_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      in_ready_q  <= (count_n != CNT_W'(DEPTH));
      out_valid_q <= (count_n != '0);
      head_q      <= head_n;
    end
  end

  // Entry storage; contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    if (push_c && !bus.flush) mem[wr_ptr] <= new_entry;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.opcode    = head_q.opcode;
  assign bus.iclass    = head_q.iclass;
  assign bus.rdst      = head_q.rdst;
  assign bus.rsrc      = head_q.rsrc;
  assign bus.cond      = head_q.cond;
  assign bus.imm       = head_q.imm_sx ? IMM_W'($signed(head_q.imm8))
                                       : IMM_W'(head_q.imm8);

`ifdef DECODE_PERF_CNT_EN
  // Counts only pushes that actually land (a flush discards the push).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (push_c && !bus.flush) begin
      if (perf_decoded != 16'hFFFF) perf_decoded <= perf_decoded + 16'd1;
      if (new_entry.iclass == CLS_ILL && perf_illegal != 16'hFFFF)
        perf_illegal <= perf_illegal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed + short random bench for decode_queue with a lock-step
// scoreboard of hand-decoded vectors.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int IMM_W = 16;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  opc;
    logic [3:0]  cls;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  cnd;
    logic [15:0] imm;
  } vec_t;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   mcount = 0;
  int   m_dec = 0;
  int   m_ill = 0;
  vec_t tbl [16];
  vec_t exp_q [$];

  decode_queue_if #(.IMM_W(IMM_W)) dq ();

`ifdef DECODE_PERF_CNT_EN
  logic [15:0] perf_decoded, perf_illegal;
`endif

  decode_queue #(.DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef DECODE_PERF_CNT_EN
    .perf_decoded (perf_decoded),
    .perf_illegal (perf_illegal),
`endif
    .bus          (dq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance the
  // model, then step to #1 after the next rising edge.
  task automatic cycle(input logic in_v, input int idx, input logic out_r, input logic fl);
    vec_t e;
    logic pop, push;
    dq.in_valid  = in_v;
    dq.instr     = tbl[idx].instr;
    dq.out_ready = out_r;
    dq.flush     = fl;
    chk("in_ready",  32'(dq.in_ready),  32'(mcount != DEPTH));
    chk("out_valid", 32'(dq.out_valid), 32'(mcount != 0));
    if (mcount != 0) e = exp_q[0];
    else e = '{16'h0, 8'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0};
    chk("opcode", 32'(dq.opcode), 32'(e.opc));
    chk("iclass", 32'(dq.iclass), 32'(e.cls));
    chk("rdst",   32'(dq.rdst),   32'(e.rd));
    chk("rsrc",   32'(dq.rsrc),   32'(e.rs));
    chk("cond",   32'(dq.cond),   32'(e.cnd));
    chk("imm",    32'(dq.imm),    32'(e.imm));
`ifdef DECODE_PERF_CNT_EN
    chk("perf_decoded", 32'(perf_decoded), 32'(m_dec));
    chk("perf_illegal", 32'(perf_illegal), 32'(m_ill));
`endif
    pop  = (mcount != 0) && out_r;
    push = in_v && (mcount != DEPTH);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(tbl[idx]);
        m_dec++;
        if (tbl[idx].cls == 4'hF) m_ill++;
      end
    end
    mcount = exp_q.size();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               instr     opc    cls   rd    rs    cnd   imm
    tbl[0]  = '{16'h5A83, 8'h5A, 4'h2, 4'hA, 4'h0, 4'h0, 16'hFF83};
    tbl[1]  = '{16'h0523, 8'h05, 4'h1, 4'h2, 4'h3, 4'h0, 16'h0000};
    tbl[2]  = '{16'hC0FE, 8'hC0, 4'hC, 4'h0, 4'h0, 4'h0, 16'hFFFE};
    tbl[3]  = '{16'h4E10, 8'h4E, 4'h8, 4'h0, 4'h0, 4'hE, 16'h0010};
    tbl[4]  = '{16'hC255, 8'hC2, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000};
    tbl[5]  = '{16'h4A33, 8'h4A, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000};
    tbl[6]  = '{16'h9370, 8'h93, 4'h2, 4'h3, 4'h0, 4'h0, 16'h0070};
    tbl[7]  = '{16'h4FA5, 8'h4F, 4'h2, 4'h5, 4'h0, 4'h0, 16'h000A};
    tbl[8]  = '{16'h8712, 8'h87, 4'h5, 4'h1, 4'h2, 4'h0, 16'h0000};
    tbl[9]  = '{16'h8534, 8'h85, 4'h4, 4'h3, 4'h4, 4'h0, 16'h0000};
    tbl[10] = '{16'h00FF, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
    tbl[11] = '{16'h8456, 8'h84, 4'h1, 4'h5, 4'h6, 4'h0, 16'h0000};
    tbl[12] = '{16'h4780, 8'h47, 4'h8, 4'h0, 4'h0, 4'h7, 16'hFF80};
    tbl[13] = '{16'hC67F, 8'hC6, 4'hC, 4'h0, 4'h0, 4'h6, 16'h007F};
    tbl[14] = '{16'h0A12, 8'h0A, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000};
    tbl[15] = '{16'hFFFF, 8'hFF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000};

    // Reset held with fetch presenting an instruction.
    reset_n      = 1'b0;
    dq.in_valid  = 1'b1;
    dq.instr     = tbl[0].instr;
    dq.out_ready = 1'b0;
    dq.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(dq.out_valid), 32'h0);
    chk("rst_in_ready",  32'(dq.in_ready),  32'h1);
    chk("rst_opcode",    32'(dq.opcode),    32'h0);
    chk("rst_iclass",    32'(dq.iclass),    32'h0);
    chk("rst_imm",       32'(dq.imm),       32'h0);
    reset_n = 1'b1;

    // First push right after reset release; no bypass to the head.
    cycle(1'b1, 0, 1'b0, 1'b0);
    chk("addi_iclass", 32'(dq.iclass), 32'h2);
    chk("addi_rdst",   32'(dq.rdst),   32'hA);
    chk("addi_imm",    32'(dq.imm),    32'hFF83);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);

    // Stream every vector with execute always ready.
    for (int i = 1; i < 16; i++) cycle(1'b1, i, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 0, 1'b1, 1'b0);

    // Fill with execute stalled, hold while full, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, i + 2, 1'b0, 1'b0);
    cycle(1'b1, 12, 1'b0, 1'b0);
    cycle(1'b1, 12, 1'b1, 1'b0);
    cycle(1'b1, 12, 1'b1, 1'b0);
    cycle(1'b1, 13, 1'b1, 1'b0);
    cycle(1'b1, 7,  1'b1, 1'b0);
    repeat (DEPTH + 1) cycle(1'b0, 0, 1'b1, 1'b0);

    // Flush with two queued entries, overriding a push and a pop.
    cycle(1'b1, 6, 1'b0, 1'b0);
    cycle(1'b1, 7, 1'b0, 1'b0);
    cycle(1'b1, 8, 1'b1, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 9, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

    // Asynchronous reset mid-operation drops all queued entries.
    cycle(1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 1, 1'b0, 1'b0);
    dq.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(dq.out_valid), 32'h0);
    chk("async_rst_in_ready",  32'(dq.in_ready),  32'h1);
    chk("async_rst_opcode",    32'(dq.opcode),    32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    mcount = 0;
    m_dec  = 0;
    m_ill  = 0;

    // Three legal and two illegal pushes, then a flush.
    cycle(1'b1, 0, 1'b1, 1'b0);
    cycle(1'b1, 1, 1'b1, 1'b0);
    cycle(1'b1, 2, 1'b1, 1'b0);
    cycle(1'b1, 4, 1'b1, 1'b0);
    cycle(1'b1, 5, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);
`ifdef DECODE_PERF_CNT_EN
    chk("perf_decoded_5", 32'(perf_decoded), 32'd5);
    chk("perf_illegal_2", 32'(perf_illegal), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
